// File: rtl/spi_register_bridge_pkg.sv
// -----------------------------------------------------------------------------
// spi_register_bridge_pkg
//   Shared definitions for the SPI command bridge. These are the command and
//   response bit positions for the default 32-bit word (ADDR_WIDTH=6,
//   DATA_WIDTH=24), and the FSM state encoding. Host-side models and benches
//   use this package so they see the same layout as the RTL.
// -----------------------------------------------------------------------------
package spi_register_bridge_pkg;

  localparam int DEF_ADDR_WIDTH = 6;
  localparam int DEF_DATA_WIDTH = 24;
  localparam int CMD_WIDTH      = DEF_DATA_WIDTH + DEF_ADDR_WIDTH + 2;

  // Command word: [WE][RSVD][addr][data]
  localparam int WE_BIT   = CMD_WIDTH - 1;
  localparam int RSVD_BIT = CMD_WIDTH - 2;
  // Response word: [OK][ERR][addr echo][data]
  localparam int OK_BIT   = CMD_WIDTH - 1;
  localparam int ERR_BIT  = CMD_WIDTH - 2;
  // Address field starts just above the data field in both words.
  localparam int ADDR_LSB = DEF_DATA_WIDTH;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_e;

endpackage

// File: rtl/spi_register_bridge.sv
// -----------------------------------------------------------------------------
// spi_register_bridge
//   Turns each word received by the SPI slave into one register-bus command
//   and loads the result into spi_value_miso. The slave then shifts that result
//   out during the following SPI transaction. Only one command is in flight at
//   a time.
//
// Ports
//   system_clk, system_nrst   clock, asynchronous active-low reset
//   spi_value_mosi/_valid     received command word plus a one-cycle strobe
//   spi_value_miso            registered response word
//   bus_req/we/addr/wdata     register bus request. bus_we, bus_addr and
//                             bus_wdata are held while bus_req is high.
//   bus_rdata/bus_ack         read data, with a one-cycle completion strobe
//   busy                      a command is in flight
//   overrun                   sticky flag. A command was dropped while busy.
//                             It is cleared when the flag is reported.
//   dbg_state_o               current FSM state, for observation
//
// Handshake: bus_req rises the cycle after an accepted command. It then stays
// high, with stable bus_we, bus_addr and bus_wdata, until the cycle after
// bus_ack or until the timeout expires. bus_ack outside a request is ignored.
// -----------------------------------------------------------------------------
module spi_register_bridge
  import spi_register_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH     = 6,
  parameter int DATA_WIDTH     = 24,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                 system_clk,
  input  logic                                 system_nrst,
  input  logic [DATA_WIDTH+ADDR_WIDTH+1:0]     spi_value_mosi,
  input  logic                                 spi_value_valid,
  output logic [DATA_WIDTH+ADDR_WIDTH+1:0]     spi_value_miso,
  output logic                                 bus_req,
  output logic                                 bus_we,
  output logic [ADDR_WIDTH-1:0]                bus_addr,
  output logic [DATA_WIDTH-1:0]                bus_wdata,
  input  logic [DATA_WIDTH-1:0]                bus_rdata,
  input  logic                                 bus_ack,
  output logic                                 busy,
  output logic                                 overrun,
  output state_e                               dbg_state_o
);

  localparam int WIDTH  = DATA_WIDTH + ADDR_WIDTH + 2;
  localparam int CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int L_WE   = WIDTH - 1;
  localparam int L_RSVD = WIDTH - 2;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e                  state_q, state_d;
  logic                    req_q, req_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    ovr_q, ovr_d;
  logic [WIDTH-1:0]        miso_q, miso_d;

  logic [ADDR_WIDTH-1:0]   cmd_addr;
  logic [DATA_WIDTH-1:0]   cmd_data;

  assign cmd_addr = spi_value_mosi[WIDTH-3:DATA_WIDTH];
  assign cmd_data = spi_value_mosi[DATA_WIDTH-1:0];

  always_ff @(posedge system_clk or negedge system_nrst) begin
    if (!system_nrst) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
      miso_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
      miso_q  <= miso_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    ovr_d   = ovr_q;
    miso_d  = miso_q;

    case (state_q)
      ST_IDLE: begin
        if (spi_value_valid) begin
          if (spi_value_mosi[L_RSVD]) begin
            // Malformed command: report an error immediately and do no bus cycle.
            miso_d = {1'b0, 1'b1, cmd_addr, {DATA_WIDTH{1'b0}}};
            ovr_d  = 1'b0;
          end else begin
            we_d    = spi_value_mosi[L_WE];
            addr_d  = cmd_addr;
            wdata_d = cmd_data;
            req_d   = 1'b1;
            cnt_d   = CNT_LOAD;
            state_d = ST_REQ;
          end
        end
      end

      ST_REQ: begin
        // A new word arriving now cannot be queued. It is dropped and flagged.
        if (spi_value_valid) ovr_d = 1'b1;

        if (bus_ack) begin
          // Ack has priority over timeout expiry in the same cycle.
          req_d   = 1'b0;
          miso_d  = {1'b1, ovr_q | spi_value_valid, addr_q,
                     we_q ? wdata_q : bus_rdata};
          ovr_d   = 1'b0;
          state_d = ST_IDLE;
        end else if (cnt_q <= CNT_ONE) begin
          // This is the last cycle of the window. bus_req has been high for
          // TIMEOUT_CYCLES cycles.
          req_d   = 1'b0;
          miso_d  = {1'b0, 1'b1, addr_q, {DATA_WIDTH{1'b0}}};
          ovr_d   = 1'b0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign spi_value_miso = miso_q;
  assign bus_req        = req_q;
  assign bus_we         = we_q;
  assign bus_addr       = addr_q;
  assign bus_wdata      = wdata_q;
  assign busy           = (state_q != ST_IDLE);
  assign overrun        = ovr_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_spi_register_bridge.sv
module tb_spi_register_bridge;
  import spi_register_bridge_pkg::*;

  localparam int W  = CMD_WIDTH;
  localparam int AW = DEF_ADDR_WIDTH;
  localparam int DW = DEF_DATA_WIDTH;
  localparam int TO = 4;

  logic          clk;
  logic          nrst;
  logic [W-1:0]  mosi;
  logic          valid;
  logic [W-1:0]  miso;
  logic          bus_req;
  logic          bus_we;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic [DW-1:0] bus_rdata;
  logic          bus_ack;
  logic          busy;
  logic          overrun;
  state_e        dbg_state;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  spi_register_bridge #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .system_clk(clk), .system_nrst(nrst),
    .spi_value_mosi(mosi), .spi_value_valid(valid), .spi_value_miso(miso),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .busy(busy), .overrun(overrun), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // The response expected by the scoreboard is popped from exp_q.
  task automatic check_resp(input string name);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: scoreboard queue empty", name);
    end else begin
      e = exp_q.pop_front();
      check(name, miso, e);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_word(input logic [W-1:0] w);
    @(negedge clk);
    mosi  = w;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
  endtask

  typedef struct {
    string         name;
    logic [W-1:0]  cmd;
    bit            do_ack;
    int            ack_at;     // req-high cycle on which ack is driven
    logic [DW-1:0] rdata;
    int            exp_cycles; // cycles bus_req stays high
    logic          exp_we;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata;
    logic [W-1:0]  exp_resp;
  } vec_t;

  // Apply a command, serve the bus and check the request and its response.
  task automatic run_vec(input vec_t v);
    int n;
    n = 0;
    exp_q.push_back(v.exp_resp);
    send_word(v.cmd);
    while (bus_req && n < 40) begin
      n++;
      check({v.name, " we"},    W'(bus_we),    W'(v.exp_we));
      check({v.name, " addr"},  W'(bus_addr),  W'(v.exp_addr));
      check({v.name, " wdata"}, W'(bus_wdata), W'(v.exp_wdata));
      if (v.do_ack && n == v.ack_at) begin
        bus_ack   = 1'b1;
        bus_rdata = v.rdata;
      end
      @(negedge clk);
      bus_ack = 1'b0;
    end
    check({v.name, " req_cycles"}, W'(n), W'(v.exp_cycles));
    check({v.name, " busy"}, W'(busy), W'(0));
    check_resp({v.name, " resp"});
  endtask

  vec_t vecs[7];

  initial begin
    int n;
    logic req_seen_low;

    vecs[0] = '{"wr_0a", 32'h8A123456, 1, 3, 24'h000000, 3, 1'b1, 6'h0A, 24'h123456, 32'h8A123456};
    vecs[1] = '{"rd_05", 32'h05000000, 1, 1, 24'hABCDEF, 1, 1'b0, 6'h05, 24'h000000, 32'h85ABCDEF};
    vecs[2] = '{"rd_timeout", 32'h05000000, 0, 0, 24'h000000, TO, 1'b0, 6'h05, 24'h000000, 32'h45000000};
    vecs[3] = '{"rsvd", 32'h41000001, 0, 0, 24'h000000, 0, 1'b0, 6'h00, 24'h000000, 32'h41000000};
    vecs[4] = '{"wr_3f", 32'hBF000001, 1, 2, 24'h555555, 2, 1'b1, 6'h3F, 24'h000001, 32'hBF000001};
    vecs[5] = '{"rd_ack_at_expiry", 32'h3FFFFFFF, 1, TO, 24'h000000, TO, 1'b0, 6'h3F, 24'hFFFFFF, 32'hBF000000};
    vecs[6] = '{"wr_zero", 32'h80000000, 1, 1, 24'hFFFFFF, 1, 1'b1, 6'h00, 24'h000000, 32'h80000000};

    nrst = 1'b0; mosi = '0; valid = 1'b0; bus_rdata = '0; bus_ack = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst req",     W'(bus_req),   W'(0));
    check("rst we",      W'(bus_we),    W'(0));
    check("rst addr",    W'(bus_addr),  W'(0));
    check("rst wdata",   W'(bus_wdata), W'(0));
    check("rst busy",    W'(busy),      W'(0));
    check("rst overrun", W'(overrun),   W'(0));
    check("rst miso",    miso,          W'(0));
    check("rst state",   W'(dbg_state), W'(ST_IDLE));
    nrst = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // An ack while idle is ignored: no request, response unchanged.
    @(negedge clk);
    bus_ack = 1'b1; bus_rdata = 24'h777777;
    @(negedge clk);
    bus_ack = 1'b0;
    check("idle_ack req",  W'(bus_req), W'(0));
    check("idle_ack miso", miso, 32'h80000000);

    // Overrun: a second word while a request is pending is dropped.
    exp_q.push_back(32'hC5111111);
    send_word(32'h05000000);
    send_word(32'h8A123456);
    check("ovr flag",  W'(overrun),  W'(1));
    check("ovr req",   W'(bus_req),  W'(1));
    check("ovr addr",  W'(bus_addr), W'(6'h05));
    check("ovr we",    W'(bus_we),   W'(0));
    bus_ack = 1'b1; bus_rdata = 24'h111111;
    @(negedge clk);
    bus_ack = 1'b0;
    check("ovr req_after", W'(bus_req), W'(0));
    check("ovr cleared",   W'(overrun), W'(0));
    check_resp("ovr resp");
    // Make sure the dropped write never started a bus cycle.
    req_seen_low = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (bus_req) req_seen_low = 1'b0;
    end
    check("ovr no_second_req", W'(req_seen_low), W'(1));

    // Asynchronous reset mid-request
    send_word(32'h05000000);
    check("arst pre_req", W'(bus_req), W'(1));
    #2 nrst = 1'b0;
    #1;
    check("arst req",   W'(bus_req), W'(0));
    check("arst busy",  W'(busy),    W'(0));
    check("arst miso",  miso,        W'(0));
    check("arst state", W'(dbg_state), W'(ST_IDLE));
    @(negedge clk);
    nrst = 1'b1;
    bus_ack = 1'b1; bus_rdata = 24'h222222;
    @(negedge clk);
    bus_ack = 1'b0;
    check("late_ack req",  W'(bus_req), W'(0));
    check("late_ack miso", miso,        W'(0));
    run_vec(vecs[0]);

    // Bounded wait for idle, as a final sanity step.
    n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("final idle", W'(busy), W'(0));
    check("scoreboard drained", W'(exp_q.size()), W'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
